// File: rtl/sensor_hit_qualifier.sv
// Synchronise, debounce and qualify raw box codes into single hit pulses.
// Define HIT_LOCKOUT_EN to add a refractory LOCK state after every release.
module sensor_hit_qualifier #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_BOXES       = 6,
  parameter int LOCKOUT_CYCLES  = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] GPIO_1,
  input  logic       enable,
  output logic [2:0] box_address,
  output logic       hit_valid,
  output logic [2:0] hit_box,
  output logic       bad_code
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES)
                         ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef HIT_LOCKOUT_EN
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, QUAL, HELD, REL, LOCK} state_e;
`else
  typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} state_e;
`endif

  state_e        state_q, state_d;
  logic [2:0]    sync1_q, sync_q;
  logic [2:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_prev_q;
  logic [2:0]    box_q, box_d;
  logic          hv_q, hv_d;
  logic [2:0]    hbox_q, hbox_d;
  logic          bad_q, bad_d;

  logic       code_ok;
  logic       code_bad;
  logic [2:0] code;

  // Out-of-range codes look like "no hit" to the FSM
  assign code_ok  = (sync_q != 3'd0) && (32'(sync_q) <= NUM_BOXES);
  assign code_bad = (sync_q != 3'd0) && !code_ok;
  assign code     = code_ok ? sync_q : 3'd0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      bad_prev_q <= 1'b0;
      box_q      <= '0;
      hv_q       <= 1'b0;
      hbox_q     <= '0;
      bad_q      <= 1'b0;
    end else begin
      sync1_q    <= GPIO_1;
      sync_q     <= sync1_q;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      bad_prev_q <= code_bad;
      box_q      <= box_d;
      hv_q       <= hv_d;
      hbox_q     <= hbox_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (code != 3'd0) begin
          state_d = QUAL;
          cand_d  = code;
          cnt_d   = '0;
        end
      end
      QUAL: begin
        if (code == cand_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (code == 3'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cand_d = code;
          cnt_d  = '0;
        end
      end
      HELD: begin
        if (code != cand_q) begin
          state_d = REL;
          cnt_d   = '0;
        end
      end
      REL: begin
        if (code == cand_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
`ifdef HIT_LOCKOUT_EN
          state_d = LOCK;
`else
          state_d = IDLE;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef HIT_LOCKOUT_EN
      LOCK: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Only the QUAL->HELD step can fire, so a press held across enable never does
  always_comb begin
    hv_d   = (state_q == QUAL) && (state_d == HELD) && enable;
    hbox_d = hv_d ? cand_q : hbox_q;
    box_d  = ((state_d == HELD) || (state_d == REL)) ? cand_d : 3'd0;
    bad_d  = code_bad && !bad_prev_q;
  end

  assign box_address = box_q;
  assign hit_valid   = hv_q;
  assign hit_box     = hbox_q;
  assign bad_code    = bad_q;

endmodule

// File: tb/tb_sensor_hit_qualifier.sv
// Directed bench for sensor_hit_qualifier with a hit scoreboard.
// Expected hits are queued at drive time and matched when hit_valid fires.
module tb_sensor_hit_qualifier;

  localparam int D  = 4;
  localparam int NB = 6;
  localparam int L  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [2:0] gpio = 3'd5;
  logic [2:0] box_address;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic       bad_code;

  typedef struct {
    logic [2:0] box;
    int         at_edge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   bad_seen = 0;
  logic hv_prev = 1'b0;

  sensor_hit_qualifier #(
    .DEBOUNCE_CYCLES(D),
    .NUM_BOXES(NB),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .GPIO_1(gpio),
    .enable(en),
    .box_address(box_address),
    .hit_valid(hit_valid),
    .hit_box(hit_box),
    .bad_code(bad_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_hit(input logic [2:0] b, input int e);
    exp_t x;
    x.box = b;
    x.at_edge = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (bad_code) bad_seen++;
    if (hit_valid) begin
      check("hv_consecutive", 32'(hv_prev), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_hit", 32'(hit_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hit_edge", cyc, e.at_edge);
        check("hit_box", 32'(hit_box), 32'(e.box));
      end
    end
    hv_prev = hit_valid;
  end

  initial begin
    int r;
    int b0;
    // 1: reset held with a code present
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_box", 32'(box_address), 0);
      check("rst_hv", 32'(hit_valid), 0);
      check("rst_hbox", 32'(hit_box), 0);
      check("rst_bad", 32'(bad_code), 0);
    end
    rst = 1'b0;
    expect_hit(3'd5, cyc + 7);
    tick(8);
    check("t1_box", 32'(box_address), 5);
    gpio = 3'd0;
    tick(L + 10);
    check("t1_idle", 32'(box_address), 0);

    // 2: clean press/hold/release
    gpio = 3'd3;
    expect_hit(3'd3, cyc + 7);
    tick(6);
    check("t2_box_pre", 32'(box_address), 0);
    tick(1);
    check("t2_box_on", 32'(box_address), 3);
    tick(13);
    gpio = 3'd0;
    r = cyc;
    tick(6);
    check("t2_box_rel", 32'(box_address), 3);
    tick(1);
    check("t2_box_off", 32'(box_address), 0);
    check("t2_cyc", cyc, r + 7);
    tick(L + 5);

    // 3: press bounce
    gpio = 3'd2;
    tick(2);
    gpio = 3'd0;
    tick(1);
    gpio = 3'd2;
    expect_hit(3'd2, cyc + 7);
    tick(10);
    check("t3_hbox", 32'(hit_box), 2);
    gpio = 3'd0;
    tick(L + 10);

    // 4: release bounce while held
    gpio = 3'd4;
    expect_hit(3'd4, cyc + 7);
    tick(10);
    gpio = 3'd0;
    tick(2);
    gpio = 3'd4;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t4_box", 32'(box_address), 4);
    end
    gpio = 3'd0;
    tick(L + 10);

    // 5: invalid code
    b0 = bad_seen;
    gpio = 3'd7;
    tick(12);
    check("t5_bad_cnt", bad_seen - b0, 1);
    check("t5_box", 32'(box_address), 0);
    check("t5_hbox", 32'(hit_box), 4);
    gpio = 3'd0;
    tick(4);

    // reset mid-debounce discards the candidate
    gpio = 3'd6;
    tick(4);
    rst = 1'b1;
    tick(2);
    check("mrst_box", 32'(box_address), 0);
    check("mrst_hbox", 32'(hit_box), 0);
    rst = 1'b0;
    expect_hit(3'd6, cyc + 7);
    tick(10);
    check("mrst_req", 32'(hit_box), 6);
    gpio = 3'd0;
    tick(L + 10);

    // 6: press held across enable 0->1
    en = 1'b0;
    gpio = 3'd1;
    tick(12);
    check("t6_box_dis", 32'(box_address), 1);
    en = 1'b1;
    tick(10);
    check("t6_hbox_keep", 32'(hit_box), 6);
    gpio = 3'd0;
    tick(L + 10);
    gpio = 3'd1;
    expect_hit(3'd1, cyc + 7);
    tick(10);
    check("t6_hbox_new", 32'(hit_box), 1);

    // re-press 3 cycles after the release debounce completes
    gpio = 3'd0;
    r = cyc;
    tick(10);
    gpio = 3'd1;
`ifdef HIT_LOCKOUT_EN
    expect_hit(3'd1, r + L + 12);
`else
    expect_hit(3'd1, cyc + 7);
`endif
    tick(L + 14);
    check("t6_repress_box", 32'(box_address), 1);
    gpio = 3'd0;
    tick(L + 10);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
